// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared state type, channel-number width and channel-list lookup for adc_seq_avg
package adc_seq_pkg;

    localparam int ADC_CH_W = 5;
    localparam int MAX_CH   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WAIT_RSP = 2'd2
    } seq_state_e;

    // Entry idx of a packed channel list, entry 0 in the least significant bits.
    function automatic logic [ADC_CH_W-1:0] ch_list_entry(
        input logic [MAX_CH*ADC_CH_W-1:0] list,
        input int unsigned                idx
    );
        return list[idx*ADC_CH_W +: ADC_CH_W];
    endfunction

endpackage

// File: rtl/adc_ch_accum.sv
// rtl/adc_ch_accum.sv - per-slot sample accumulator and window counter; peak hold when ADC_SEQ_PEAK_HOLD_EN is defined
module adc_ch_accum #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
`ifdef ADC_SEQ_PEAK_HOLD_EN
    output logic [DATA_W-1:0] win_peak,
`endif
    output logic              win_done,
    output logic [DATA_W-1:0] win_avg
);

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] sum_shr;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Add the new sample; on the last sample of a window report the average and restart.
    always_comb begin
        sum      = acc_q + ACC_W'(sample_data);
        sum_shr  = sum >> AVG_LOG2;
        win_done = sample_valid && (cnt_q == CNT_LAST);
        win_avg  = sum_shr[DATA_W-1:0];
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (win_done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_valid) begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Accumulator and sample-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef ADC_SEQ_PEAK_HOLD_EN
    logic [DATA_W-1:0] peak_q, peak_d, peak_new;

    // Running maximum of the window, including the sample arriving now.
    always_comb begin
        peak_new = (sample_data > peak_q) ? sample_data : peak_q;
        win_peak = peak_new;
        peak_d   = peak_q;
        if (win_done) begin
            peak_d = '0;
        end else if (sample_valid) begin
            peak_d = peak_new;
        end
    end

    // Peak register clears together with the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end
`endif

endmodule

// File: rtl/adc_seq_avg.sv
// rtl/adc_seq_avg.sv - round-robin ADC command sequencer with per-channel averaging; result_peak added by ADC_SEQ_PEAK_HOLD_EN
module adc_seq_avg
    import adc_seq_pkg::*;
#(
    parameter int                         NUM_CH   = 4,
    parameter logic [NUM_CH*ADC_CH_W-1:0] CH_LIST  = {5'd4, 5'd3, 5'd2, 5'd1},
    parameter int                         DATA_W   = 12,
    parameter int                         AVG_LOG2 = 3,
    parameter int                         TIMEOUT  = 255,
    localparam int                        IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clock_clk,
    input  logic                reset_sink_reset,
    input  logic                enable,
    output logic                command_valid,
    output logic [ADC_CH_W-1:0] command_channel,
    output logic                command_startofpacket,
    output logic                command_endofpacket,
    input  logic                command_ready,
    input  logic                response_valid,
    input  logic [ADC_CH_W-1:0] response_channel,
    input  logic [DATA_W-1:0]   response_data,
    input  logic                response_startofpacket,
    input  logic                response_endofpacket,
    output logic                result_valid,
    output logic [IDX_W-1:0]    result_index,
    output logic [ADC_CH_W-1:0] result_channel,
    output logic [DATA_W-1:0]   result_data,
`ifdef ADC_SEQ_PEAK_HOLD_EN
    output logic [DATA_W-1:0]   result_peak,
`endif
    output logic                err_mismatch,
    output logic                err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [MAX_CH*ADC_CH_W-1:0] CH_LIST_EXT = (MAX_CH*ADC_CH_W)'(CH_LIST);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d, tmo_inc;
    logic                command_valid_q, command_valid_d;
    logic [ADC_CH_W-1:0] command_channel_q, command_channel_d;
    logic                result_valid_q, result_valid_d;
    logic [IDX_W-1:0]    result_index_q, result_index_d;
    logic [ADC_CH_W-1:0] result_channel_q, result_channel_d;
    logic [DATA_W-1:0]   result_data_q, result_data_d;
    logic                err_mismatch_q, err_mismatch_d;
    logic                err_timeout_q, err_timeout_d;

    logic [ADC_CH_W-1:0] cur_ch;
    logic                rsp_take, rsp_match, tmo_hit;
    logic [NUM_CH-1:0]   done_vec;
    logic [DATA_W-1:0]   avg_vec [NUM_CH];

    // Packet framing on the response side carries no information here.
    logic unused_rsp_framing;
    assign unused_rsp_framing = response_startofpacket ^ response_endofpacket;

`ifdef ADC_SEQ_PEAK_HOLD_EN
    logic [DATA_W-1:0] peak_vec [NUM_CH];
    logic [DATA_W-1:0] result_peak_q, result_peak_d;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        adc_ch_accum #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_accum (
            .clk          (clock_clk),
            .rst          (reset_sink_reset),
            .sample_valid (rsp_match && (idx_q == IDX_W'(g))),
            .sample_data  (response_data),
`ifdef ADC_SEQ_PEAK_HOLD_EN
            .win_peak     (peak_vec[g]),
`endif
            .win_done     (done_vec[g]),
            .win_avg      (avg_vec[g])
        );
    end

    // Sequencer next state, slot advance, timeout counting and next values of all registered outputs.
    always_comb begin
        cur_ch    = ch_list_entry(CH_LIST_EXT, 32'(idx_q));
        tmo_inc   = tmo_q + 1'b1;
        rsp_take  = (state_q == WAIT_RSP) && response_valid;
        rsp_match = rsp_take && (response_channel == cur_ch);
        // The slot is abandoned in the cycle the counter would reach TIMEOUT; a response in that cycle wins.
        tmo_hit   = (state_q == WAIT_RSP) && !response_valid && (tmo_inc == TMO_LIMIT);

        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                // command_valid is high for the whole CMD state, so ready alone completes the handshake.
                if (command_ready) begin
                    state_d = WAIT_RSP;
                    tmo_d   = '0;
                end
            end
            WAIT_RSP: begin
                tmo_d = tmo_inc;
                if (rsp_take || tmo_hit) begin
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    state_d = enable ? CMD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        command_valid_d   = (state_d == CMD);
        command_channel_d = command_valid_d ? ch_list_entry(CH_LIST_EXT, 32'(idx_d)) : command_channel_q;

        result_valid_d   = rsp_match && done_vec[idx_q];
        result_index_d   = result_valid_d ? idx_q : result_index_q;
        result_channel_d = result_valid_d ? cur_ch : result_channel_q;
        result_data_d    = result_valid_d ? avg_vec[idx_q] : result_data_q;
`ifdef ADC_SEQ_PEAK_HOLD_EN
        result_peak_d    = result_valid_d ? peak_vec[idx_q] : result_peak_q;
`endif
        err_mismatch_d   = rsp_take && !rsp_match;
        err_timeout_d    = tmo_hit;
    end

    // FSM and registered outputs.
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            tmo_q             <= '0;
            command_valid_q   <= 1'b0;
            command_channel_q <= '0;
            result_valid_q    <= 1'b0;
            result_index_q    <= '0;
            result_channel_q  <= '0;
            result_data_q     <= '0;
`ifdef ADC_SEQ_PEAK_HOLD_EN
            result_peak_q     <= '0;
`endif
            err_mismatch_q    <= 1'b0;
            err_timeout_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            tmo_q             <= tmo_d;
            command_valid_q   <= command_valid_d;
            command_channel_q <= command_channel_d;
            result_valid_q    <= result_valid_d;
            result_index_q    <= result_index_d;
            result_channel_q  <= result_channel_d;
            result_data_q     <= result_data_d;
`ifdef ADC_SEQ_PEAK_HOLD_EN
            result_peak_q     <= result_peak_d;
`endif
            err_mismatch_q    <= err_mismatch_d;
            err_timeout_q     <= err_timeout_d;
        end
    end

    assign command_valid         = command_valid_q;
    assign command_channel       = command_channel_q;
    assign command_startofpacket = command_valid_q;
    assign command_endofpacket   = command_valid_q;
    assign result_valid          = result_valid_q;
    assign result_index          = result_index_q;
    assign result_channel        = result_channel_q;
    assign result_data           = result_data_q;
`ifdef ADC_SEQ_PEAK_HOLD_EN
    assign result_peak           = result_peak_q;
`endif
    assign err_mismatch          = err_mismatch_q;
    assign err_timeout           = err_timeout_q;

endmodule

// File: tb/tb_adc_seq_avg.sv
// tb/tb_adc_seq_avg.sv - scoreboard bench for adc_seq_avg; peak checks enabled by ADC_SEQ_PEAK_HOLD_EN
module tb_adc_seq_avg;

    localparam int TMO = 255;
    localparam logic [2:0] EV_RES = 3'b100;
    localparam logic [2:0] EV_MIS = 3'b010;
    localparam logic [2:0] EV_TMO = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, cmd_ready, rsp_valid, rsp_sop, rsp_eop;
    logic [4:0]  rsp_ch;
    logic [11:0] rsp_data;
    logic        command_valid, command_startofpacket, command_endofpacket;
    logic [4:0]  command_channel;
    logic        result_valid, err_mismatch, err_timeout;
    logic [1:0]  result_index;
    logic [4:0]  result_channel;
    logic [11:0] result_data;

    logic        p0_en, p0_ready, p0_rsp_valid;
    logic [4:0]  p0_rsp_ch;
    logic [11:0] p0_rsp_data;
    logic        p0_cmd_valid, p0_cmd_sop, p0_cmd_eop;
    logic [4:0]  p0_cmd_ch;
    logic        p0_result_valid, p0_err_mismatch, p0_err_timeout;
    logic [0:0]  p0_result_index;
    logic [4:0]  p0_result_channel;
    logic [11:0] p0_result_data;
`ifdef ADC_SEQ_PEAK_HOLD_EN
    logic [11:0] result_peak, p0_result_peak;
`endif

    adc_seq_avg u_dut (
        .clock_clk              (clk),
        .reset_sink_reset       (rst),
        .enable                 (en),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .command_ready          (cmd_ready),
        .response_valid         (rsp_valid),
        .response_channel       (rsp_ch),
        .response_data          (rsp_data),
        .response_startofpacket (rsp_sop),
        .response_endofpacket   (rsp_eop),
        .result_valid           (result_valid),
        .result_index           (result_index),
        .result_channel         (result_channel),
        .result_data            (result_data),
`ifdef ADC_SEQ_PEAK_HOLD_EN
        .result_peak            (result_peak),
`endif
        .err_mismatch           (err_mismatch),
        .err_timeout            (err_timeout)
    );

    adc_seq_avg #(
        .NUM_CH   (1),
        .CH_LIST  (5'd6),
        .AVG_LOG2 (0),
        .TIMEOUT  (15)
    ) u_p0 (
        .clock_clk              (clk),
        .reset_sink_reset       (rst),
        .enable                 (p0_en),
        .command_valid          (p0_cmd_valid),
        .command_channel        (p0_cmd_ch),
        .command_startofpacket  (p0_cmd_sop),
        .command_endofpacket    (p0_cmd_eop),
        .command_ready          (p0_ready),
        .response_valid         (p0_rsp_valid),
        .response_channel       (p0_rsp_ch),
        .response_data          (p0_rsp_data),
        .response_startofpacket (rsp_sop),
        .response_endofpacket   (rsp_eop),
        .result_valid           (p0_result_valid),
        .result_index           (p0_result_index),
        .result_channel         (p0_result_channel),
        .result_data            (p0_result_data),
`ifdef ADC_SEQ_PEAK_HOLD_EN
        .result_peak            (p0_result_peak),
`endif
        .err_mismatch           (p0_err_mismatch),
        .err_timeout            (p0_err_timeout)
    );

    typedef struct {
        logic [2:0] kind;
        int         at;
        int         idx;
        int         ch;
        int         data;
        int         peak;
    } ev_t;

    ev_t sb[$];
    ev_t sb0[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  acc_m[4];
    int  cnt_m[4];
    int  pk_m[4];
    int  idx_m = 0;

    // One clock step; every pulse of either DUT is matched against the head of its scoreboard.
    task automatic tick();
        logic [2:0] obs;
        ev_t        e;
        bit         bad;
        @(posedge clk);
        #1;
        cyc++;
        obs = {result_valid, err_mismatch, err_timeout};
        if (obs != 3'b000 || (sb.size() > 0 && sb[0].at == cyc)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL main_pulse cyc=%0d got=%b want=none", cyc, obs);
            end else begin
                e   = sb.pop_front();
                bad = (obs !== e.kind) || (cyc != e.at);
                if (e.kind == EV_RES) begin
                    bad = bad || (32'(result_index) !== e.idx) || (32'(result_channel) !== e.ch)
                              || (32'(result_data) !== e.data);
`ifdef ADC_SEQ_PEAK_HOLD_EN
                    bad = bad || (32'(result_peak) !== e.peak);
`endif
                end
                if (bad) begin
                    failures++;
                    $display("FAIL main_pulse cyc=%0d got kind=%b idx=%0d ch=%0d data=%0d want kind=%b at=%0d idx=%0d ch=%0d data=%0d peak=%0d",
                             cyc, obs, result_index, result_channel, result_data, e.kind, e.at, e.idx, e.ch, e.data, e.peak);
                end
            end
        end
        obs = {p0_result_valid, p0_err_mismatch, p0_err_timeout};
        if (obs != 3'b000 || (sb0.size() > 0 && sb0[0].at == cyc)) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL p0_pulse cyc=%0d got=%b want=none", cyc, obs);
            end else begin
                e   = sb0.pop_front();
                bad = (obs !== e.kind) || (cyc != e.at) || (32'(p0_result_data) !== e.data)
                      || (32'(p0_result_channel) !== e.ch);
`ifdef ADC_SEQ_PEAK_HOLD_EN
                bad = bad || (32'(p0_result_peak) !== e.peak);
`endif
                if (bad) begin
                    failures++;
                    $display("FAIL p0_pulse cyc=%0d got kind=%b ch=%0d data=%0d want kind=%b at=%0d ch=%0d data=%0d",
                             cyc, obs, p0_result_channel, p0_result_data, e.kind, e.at, e.ch, e.data);
                end
            end
        end
    endtask

    // One sequencer slot on the main DUT: stall ready, accept, then answer after dly cycles or stay silent.
    task automatic do_slot(input int stall, input int dly, input bit respond,
                           input logic [4:0] rsp_ch_i, input logic [11:0] data, input bit drop_en);
        int exp_ch;
        int a;
        bit ok;
        exp_ch = idx_m + 1;
        for (int k = 0; k < 20 && command_valid !== 1'b1; k++) tick();
        checks++;
        if (command_valid !== 1'b1 || 32'(command_channel) !== exp_ch
            || command_startofpacket !== 1'b1 || command_endofpacket !== 1'b1) begin
            failures++;
            $display("FAIL cmd_issue cyc=%0d valid=%b ch=%0d sop=%b eop=%b want valid=1 ch=%0d sop=1 eop=1",
                     cyc, command_valid, command_channel, command_startofpacket, command_endofpacket, exp_ch);
        end
        if (stall > 0) begin
            ok = 1'b1;
            rsp_valid = 1'b1;
            rsp_ch    = 5'd31;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (command_valid !== 1'b1 || 32'(command_channel) !== exp_ch) ok = 1'b0;
            end
            rsp_valid = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL cmd_hold cyc=%0d valid=%b ch=%0d want valid=1 ch=%0d", cyc, command_valid, command_channel, exp_ch);
            end
        end
        cmd_ready = 1'b1;
        a = cyc;
        tick();
        cmd_ready = 1'b0;
        if (drop_en) en = 1'b0;
        checks++;
        if (command_valid !== 1'b0) begin
            failures++;
            $display("FAIL cmd_single cyc=%0d valid=%b want 0", cyc, command_valid);
        end
        if (respond) begin
            for (int s = 1; s < dly; s++) tick();
            rsp_valid = 1'b1;
            rsp_ch    = rsp_ch_i;
            rsp_data  = data;
            if (32'(rsp_ch_i) == exp_ch) begin
                acc_m[idx_m] += 32'(data);
                cnt_m[idx_m]++;
                if (32'(data) > pk_m[idx_m]) pk_m[idx_m] = 32'(data);
                if (cnt_m[idx_m] == 8) begin
                    sb.push_back('{EV_RES, cyc + 1, idx_m, exp_ch, acc_m[idx_m] / 8, pk_m[idx_m]});
                    acc_m[idx_m] = 0;
                    cnt_m[idx_m] = 0;
                    pk_m[idx_m]  = 0;
                end
            end else begin
                sb.push_back('{EV_MIS, cyc + 1, 0, 0, 0, 0});
            end
            tick();
            rsp_valid = 1'b0;
        end else begin
            sb.push_back('{EV_TMO, a + TMO + 1, 0, 0, 0, 0});
            while (cyc < a + TMO + 1) tick();
        end
        idx_m = (idx_m + 1) % 4;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_sop = 1'b0; rsp_eop = 1'b0;
        rsp_ch = '0; rsp_data = '0;
        p0_en = 1'b0; p0_ready = 1'b0; p0_rsp_valid = 1'b0; p0_rsp_ch = '0; p0_rsp_data = '0;
        tick();
        tick();
        checks++;
        if ({command_valid, command_channel, command_startofpacket, command_endofpacket} !== 8'h00) begin
            failures++;
            $display("FAIL reset_cmd valid=%b ch=%0d sop=%b eop=%b want all 0", command_valid, command_channel,
                     command_startofpacket, command_endofpacket);
        end
        checks++;
        if ({result_valid, result_index, result_channel, result_data} !== 20'h0) begin
            failures++;
            $display("FAIL reset_result valid=%b idx=%0d ch=%0d data=%0d want all 0", result_valid, result_index,
                     result_channel, result_data);
        end
        checks++;
        if ({err_mismatch, err_timeout, p0_cmd_valid, p0_result_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_err mis=%b tmo=%b p0_cmd=%b p0_res=%b want 0", err_mismatch, err_timeout,
                     p0_cmd_valid, p0_result_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (command_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_disabled valid=%b want 0", command_valid);
        end
    endtask

    task automatic test_pass_through();
        logic [11:0] vals [3];
        vals = '{12'hFFF, 12'h800, 12'h001};
        p0_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 20 && p0_cmd_valid !== 1'b1; k++) tick();
            checks++;
            if (p0_cmd_valid !== 1'b1 || p0_cmd_ch !== 5'd6) begin
                failures++;
                $display("FAIL p0_cmd cyc=%0d valid=%b ch=%0d want valid=1 ch=6", cyc, p0_cmd_valid, p0_cmd_ch);
            end
            p0_ready = 1'b1;
            tick();
            p0_ready     = 1'b0;
            p0_rsp_valid = 1'b1;
            p0_rsp_ch    = 5'd6;
            p0_rsp_data  = vals[i];
            sb0.push_back('{EV_RES, cyc + 1, 0, 6, 32'(vals[i]), 32'(vals[i])});
            tick();
            p0_rsp_valid = 1'b0;
        end
        p0_en = 1'b0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_average();
        en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                do_slot(0, 2, 1'b1, 5'(c + 1), (c == 0) ? 12'(100 + r) : 12'($urandom_range(4095)), 1'b0);
                if (c == 0 && r == 7) begin
                    checks++;
                    if (result_data !== 12'd103 || result_index !== 2'd0 || result_channel !== 5'd1) begin
                        failures++;
                        $display("FAIL avg_ch1 data=%0d idx=%0d ch=%0d want data=103 idx=0 ch=1", result_data,
                                 result_index, result_channel);
                    end
                end
            end
        end
    endtask

    task automatic test_ready_stall();
        do_slot(10, 2, 1'b1, 5'd1, 12'($urandom_range(4095)), 1'b0);
    endtask

    task automatic test_mismatch();
        do_slot(0, 2, 1'b1, 5'd7, 12'd55, 1'b0);
        for (int s = 0; s < 34; s++) do_slot(0, 2, 1'b1, 5'(idx_m + 1), 12'($urandom_range(4095)), 1'b0);
    endtask

    task automatic test_timeout();
        do_slot(0, 2, 1'b0, 5'd0, 12'd0, 1'b0);
        do_slot(0, 2, 1'b1, 5'(idx_m + 1), 12'($urandom_range(4095)), 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 12; s++) do_slot(0, 1, 1'b1, 5'(idx_m + 1), 12'($urandom_range(4095)), 1'b0);
    endtask

    task automatic test_disable();
        bit quiet;
        do_slot(0, 2, 1'b1, 5'(idx_m + 1), 12'($urandom_range(4095)), 1'b1);
        quiet     = 1'b1;
        rsp_valid = 1'b1;
        rsp_ch    = 5'd30;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (command_valid !== 1'b0) quiet = 1'b0;
        end
        rsp_valid = 1'b0;
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL disable_idle cyc=%0d valid=%b want 0", cyc, command_valid);
        end
        en = 1'b1;
        for (int s = 0; s < 8; s++) do_slot(0, 2, 1'b1, 5'(idx_m + 1), 12'($urandom_range(4095)), 1'b0);
    endtask

    task automatic test_reset_mid();
        while (idx_m != 2) do_slot(0, 2, 1'b1, 5'(idx_m + 1), 12'($urandom_range(4095)), 1'b0);
        for (int k = 0; k < 20 && command_valid !== 1'b1; k++) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({command_valid, command_channel, result_valid, result_index, result_channel, result_data,
             err_mismatch, err_timeout} !== 29'h0) begin
            failures++;
            $display("FAIL reset_mid valid=%b ch=%0d res=%b idx=%0d rch=%0d data=%0d mis=%b tmo=%b want all 0",
                     command_valid, command_channel, result_valid, result_index, result_channel, result_data,
                     err_mismatch, err_timeout);
        end
        rst = 1'b0;
        idx_m = 0;
        for (int i = 0; i < 4; i++) begin
            acc_m[i] = 0;
            cnt_m[i] = 0;
            pk_m[i]  = 0;
        end
        for (int k = 0; k < 20 && command_valid !== 1'b1; k++) tick();
        checks++;
        if (command_valid !== 1'b1 || command_channel !== 5'd1) begin
            failures++;
            $display("FAIL reset_mid_next valid=%b ch=%0d want valid=1 ch=1", command_valid, command_channel);
        end
    endtask

`ifdef ADC_SEQ_PEAK_HOLD_EN
    task automatic test_peak();
        int pk [8];
        pk = '{10, 500, 20, 30, 40, 50, 60, 70};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                do_slot(0, 2, 1'b1, 5'(c + 1), (c == 0) ? 12'(pk[r]) : 12'($urandom_range(4095)), 1'b0);
                if (c == 0 && r == 7) begin
                    checks++;
                    if (result_peak !== 12'd500 || result_data !== 12'd97) begin
                        failures++;
                        $display("FAIL peak_ch1 peak=%0d data=%0d want peak=500 data=97", result_peak, result_data);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            acc_m[i] = 0;
            cnt_m[i] = 0;
            pk_m[i]  = 0;
        end
        test_reset();
        test_pass_through();
        test_average();
        test_ready_stall();
        test_mismatch();
        test_timeout();
        test_back_to_back();
        test_disable();
        test_reset_mid();
`ifdef ADC_SEQ_PEAK_HOLD_EN
        test_peak();
`endif
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (sb.size() != 0 || sb0.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d p0_left=%0d want 0", sb.size(), sb0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1);
    end

endmodule
